// File: rtl/csa_resolver.sv
// csa_resolver: resolves a carry-save pair (carry, sum) into the binary value
// 2*carry + sum. The addition is done CHUNK bits per cycle, with a carry flop
// linking one chunk to the next. There are valid/ready handshakes on both sides.
//
// Optional build macro: CSA_RESOLVER_ZERO_BYPASS_EN
//   When it is defined, a pair whose carry vector is zero skips the chunked
//   add. The sum is loaded straight into the result and the FSM goes to DONE.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no pair held; ready to accept
// ADD   | resolving one chunk per cycle, counter selects the chunk
// DONE  | result valid; may accept the next pair when out_ready is high
module csa_resolver #(
  parameter int WIDTH = 38,
  parameter int CHUNK = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_carry,
  input  logic [WIDTH-1:0]   in_sum,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH+1:0]   out_sum
);

  localparam int RW     = WIDTH + 2;
  localparam int NCHUNK = (RW + CHUNK - 1) / CHUNK;
  // Operand registers are padded to a whole number of chunks, so the last
  // (partial) chunk reads zeros above RW-1.
  localparam int PW     = NCHUNK * CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic [PW-1:0]   a_q, a_d;
  logic [PW-1:0]   b_q, b_d;
  logic [RW-1:0]   res_q, res_d;

  logic            accept;
  logic            last_chunk;
  logic [CHUNK:0]  chunk_sum;
  logic [PW-1:0]   chunk_mask;
  logic [PW-1:0]   chunk_ins;

  // Handshake outputs depend only on state, plus out_ready while in DONE.
  always_comb begin
    in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    out_valid = (state_q == S_DONE);
    accept    = in_valid && in_ready;
    out_sum   = res_q;
  end

  // Chunk adder. Operands are shifted down each cycle, so chunk k always sits
  // in the low CHUNK bits. The result chunk is merged back in at position k.
  always_comb begin
    chunk_sum  = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
               + (CHUNK+1)'(carry_q);
    last_chunk = (cnt_q == CW'(NCHUNK - 1));
    chunk_mask = PW'({CHUNK{1'b1}}) << (int'(cnt_q) * CHUNK);
    chunk_ins  = PW'(chunk_sum[CHUNK-1:0]) << (int'(cnt_q) * CHUNK);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          a_d     = PW'({in_carry, 1'b0});
          b_d     = PW'(in_sum);
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = S_ADD;
`ifdef CSA_RESOLVER_ZERO_BYPASS_EN
          if (in_carry == '0) begin
            res_d   = RW'(in_sum);
            state_d = S_DONE;
          end
`endif
        end else if ((state_q == S_DONE) && out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_ADD: begin
        // Bits of the last chunk above RW-1 are dropped by the truncating cast.
        res_d   = RW'((PW'(res_q) & ~chunk_mask) | chunk_ins);
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = chunk_sum[CHUNK];
        cnt_d   = cnt_q + 1'b1;
        if (last_chunk) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers. Reset clears everything at once, so a
  // partial result is never presented.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

endmodule
